// File: rtl/rr_dispatcher.sv
// rtl/rr_dispatcher.sv - single-slot round-robin dispatcher from one upstream stream to N consumers
module rr_dispatcher #(
  parameter int N = 8,
  parameter int D = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [D-1:0] i_data,
  input  logic [N-1:0] i_en,
  output logic [N-1:0] o_valid,
  input  logic [N-1:0] i_ready,
  output logic [D-1:0] o_data
);

  localparam int W = $clog2(N);
  localparam logic [W:0]   N_W   = (W+1)'(N);
  localparam logic [W-1:0] LAST  = W'(N - 1);

  logic         full_q, full_d;
  logic [D-1:0] data_q, data_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic         load;
  logic         sel_found;
  logic [W-1:0] sel_idx;
  logic [W:0]   cand;

  assign accept  = full_q && i_ready[tgt_q];
  assign o_ready = !i_rst && (|i_en) && (!full_q || accept);
  assign load    = i_valid && o_ready;
  assign o_data  = data_q;

  // Output valid comes only from registered state, so it never follows i_ready/i_valid.
  always_comb begin
    o_valid = '0;
    if (full_q && !i_rst) begin
      o_valid[tgt_q] = 1'b1;
    end
  end

  // First enabled index at or after ptr, wrapping N-1 to 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (W+1)'(i);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (!sel_found && i_en[cand[W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[W-1:0];
      end
    end
  end

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    tgt_d  = tgt_q;
    ptr_d  = ptr_q;
    if (accept) begin
      full_d = 1'b0;
    end
    if (load) begin
      full_d = 1'b1;
      data_d = i_data;
      tgt_d  = sel_idx;
      ptr_d  = (sel_idx == LAST) ? '0 : sel_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      tgt_q  <= '0;
      ptr_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      tgt_q  <= tgt_d;
      ptr_q  <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_dispatcher.sv
// tb/tb_rr_dispatcher.sv - directed-vector bench for rr_dispatcher
module tb_rr_dispatcher;

  localparam int N = 8;
  localparam int D = 32;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [D-1:0] i_data = '0;
  logic [N-1:0] i_en = '0;
  logic [N-1:0] o_valid;
  logic [N-1:0] i_ready = '0;
  logic [D-1:0] o_data;

  int vectors = 0;
  int miscompares = 0;

  rr_dispatcher #(.N(N), .D(D)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_en    (i_en),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b1; i_en = 8'hFF; i_ready = 8'hFF; i_data = 32'hDEAD_BEEF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      vectors++;
      if (o_ready !== 1'b0) begin miscompares++; $display("FAIL reset_o_ready: got %b required 0", o_ready); end
      vectors++;
      if (o_valid !== 8'h00) begin miscompares++; $display("FAIL reset_o_valid: got %h required 00", o_valid); end
    end
    @(negedge clk);
    i_rst = 1'b0; i_valid = 1'b0; #1;
    vectors++;
    if (o_data !== 32'h0) begin miscompares++; $display("FAIL reset_o_data: got %h required 0", o_data); end
    vectors++;
    if (o_valid !== 8'h00) begin miscompares++; $display("FAIL reset_release_valid: got %h required 00", o_valid); end
  endtask

  task automatic test_stream();
    logic [7:0] exp_v;
    i_en = 8'hFF; i_ready = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      i_valid = 1'b1; i_data = k; #1;
      vectors++;
      if (o_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready[%0d]: got %b required 1", k, o_ready); end
      if (k > 0) begin
        exp_v = 8'h01 << ((k - 1) % 8);
        vectors++;
        if (o_valid !== exp_v) begin miscompares++; $display("FAIL stream_valid[%0d]: got %h required %h", k, o_valid, exp_v); end
        vectors++;
        if (o_data !== 32'(k - 1)) begin miscompares++; $display("FAIL stream_data[%0d]: got %0d required %0d", k, o_data, k - 1); end
      end
    end
    @(negedge clk);
    i_valid = 1'b0; #1;
    vectors++;
    if (o_valid !== 8'h02 || o_data !== 32'd9) begin miscompares++; $display("FAIL stream_last: got %h/%0d required 02/9", o_valid, o_data); end
    @(negedge clk); #1;
    vectors++;
    if (o_valid !== 8'h00) begin miscompares++; $display("FAIL stream_drain: got %h required 00", o_valid); end
  endtask

  task automatic test_mask();
    int tg [6] = '{0, 2, 5, 7, 0, 2};
    @(negedge clk); i_rst = 1'b1; i_valid = 1'b0;
    @(negedge clk); i_rst = 1'b0;
    i_en = 8'hA5; i_ready = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        vectors++;
        if (o_valid !== (8'h01 << tg[k-1]) || o_data !== 32'(100 + k - 1)) begin
          miscompares++; $display("FAIL mask_target[%0d]: got %h/%0d required %h/%0d", k - 1, o_valid, o_data, 8'h01 << tg[k-1], 100 + k - 1);
        end
      end
      i_valid = 1'b1; i_data = 100 + k;
      @(negedge clk); #1;
    end
    i_valid = 1'b0; i_ready = 8'h00; #1;
    vectors++;
    if (o_valid !== 8'h04 || o_data !== 32'd105) begin miscompares++; $display("FAIL mask_last: got %h/%0d required 04/105", o_valid, o_data); end
    i_en = 8'h10; #1;
    vectors++;
    if (o_valid !== 8'h04 || o_ready !== 1'b0) begin miscompares++; $display("FAIL mask_en_change: got %h/%b required 04/0", o_valid, o_ready); end
    @(negedge clk); #1;
    vectors++;
    if (o_valid !== 8'h04 || o_data !== 32'd105) begin miscompares++; $display("FAIL mask_en_hold: got %h/%0d required 04/105", o_valid, o_data); end
    i_ready = 8'hFF; i_en = 8'hFF; #1;
    vectors++;
    if (o_ready !== 1'b1) begin miscompares++; $display("FAIL mask_drain_ready: got %b required 1", o_ready); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    i_rst = 1'b1; i_valid = 1'b0;
    @(negedge clk); i_rst = 1'b0;
    i_en = 8'hFF; i_ready = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_data = 200 + k;
      @(negedge clk);
    end
    i_ready = 8'hF7; i_data = 204;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (o_valid !== 8'h08 || o_data !== 32'd203 || o_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold[%0d]: got %h/%0d/%b required 08/203/0", c, o_valid, o_data, o_ready);
      end
      @(negedge clk);
    end
    i_ready = 8'hFF; #1;
    vectors++;
    if (o_ready !== 1'b1 || o_valid !== 8'h08) begin miscompares++; $display("FAIL bp_release: got %b/%h required 1/08", o_ready, o_valid); end
    @(negedge clk);
    i_valid = 1'b0; #1;
    vectors++;
    if (o_valid !== 8'h10 || o_data !== 32'd204) begin miscompares++; $display("FAIL bp_reload: got %h/%0d required 10/204", o_valid, o_data); end
    @(negedge clk);
  endtask

  task automatic test_empty_mask();
    i_en = 8'hFF; i_ready = 8'h00; i_valid = 1'b1; i_data = 300;
    @(negedge clk);
    i_en = 8'h00; i_data = 301; #1;
    vectors++;
    if (o_ready !== 1'b0 || o_valid !== 8'h20) begin miscompares++; $display("FAIL empty_hold: got %b/%h required 0/20", o_ready, o_valid); end
    @(negedge clk);
    i_ready = 8'hFF; #1;
    vectors++;
    if (o_ready !== 1'b0 || o_valid !== 8'h20) begin miscompares++; $display("FAIL empty_drain_ready: got %b/%h required 0/20", o_ready, o_valid); end
    @(negedge clk); #1;
    vectors++;
    if (o_valid !== 8'h00 || o_data !== 32'd300) begin miscompares++; $display("FAIL empty_drained: got %h/%0d required 00/300", o_valid, o_data); end
    i_en = 8'h40; i_data = 302; #1;
    vectors++;
    if (o_ready !== 1'b1) begin miscompares++; $display("FAIL empty_reenable: got %b required 1", o_ready); end
    @(negedge clk);
    i_valid = 1'b0; i_en = 8'hFF; #1;
    vectors++;
    if (o_valid !== 8'h40 || o_data !== 32'd302) begin miscompares++; $display("FAIL empty_tgt6: got %h/%0d required 40/302", o_valid, o_data); end
    @(negedge clk);
    i_valid = 1'b1; i_data = 303;
    @(negedge clk);
    i_valid = 1'b0; #1;
    vectors++;
    if (o_valid !== 8'h80 || o_data !== 32'd303) begin miscompares++; $display("FAIL empty_ptr7: got %h/%0d required 80/303", o_valid, o_data); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    i_en = 8'h20; i_ready = 8'h00; i_valid = 1'b1; i_data = 400;
    @(negedge clk); #1;
    vectors++;
    if (o_valid !== 8'h20) begin miscompares++; $display("FAIL midrst_pre: got %h required 20", o_valid); end
    i_rst = 1'b1; i_en = 8'hFF; i_data = 401; #1;
    vectors++;
    if (o_valid !== 8'h00 || o_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_during: got %h/%b required 00/0", o_valid, o_ready); end
    @(negedge clk);
    i_rst = 1'b0; i_valid = 1'b0; #1;
    vectors++;
    if (o_valid !== 8'h00 || o_data !== 32'd0) begin miscompares++; $display("FAIL midrst_lost: got %h/%0d required 00/0", o_valid, o_data); end
    i_en = 8'h0C; i_valid = 1'b1; i_data = 402;
    @(negedge clk);
    i_valid = 1'b0; #1;
    vectors++;
    if (o_valid !== 8'h04 || o_data !== 32'd402) begin miscompares++; $display("FAIL midrst_next: got %h/%0d required 04/402", o_valid, o_data); end
    i_ready = 8'hFF;
    @(negedge clk); #1;
    vectors++;
    if (o_valid !== 8'h00) begin miscompares++; $display("FAIL midrst_drain: got %h required 00", o_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mask();
    test_backpressure();
    test_empty_mask();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
